// File: rtl/popcount_pkg.sv
// Shared types and helpers for the pipelined population counter.
package popcount_pkg;

    localparam int MAX_WIDTH = 256;

    // Per-beat control travelling alongside the partial counts.
    typedef struct packed {
        logic vld;
        logic acc;
        logic last;
    } beat_ctl_t;

    // Range of reduction levels [lo, hi) evaluated within one pipeline stage.
    typedef struct packed {
        int lo;
        int hi;
    } lvl_span_t;

    function automatic int cnt_width(int w);
        return $clog2(w + 1);
    endfunction

    function automatic lvl_span_t stage_span(int nlvl, int lat, int s);
        lvl_span_t sp;
        sp.lo = (s * nlvl) / lat;
        sp.hi = ((s + 1) * nlvl) / lat;
        return sp;
    endfunction

endpackage

// File: rtl/popcount_if.sv
// Input beat and output result channels of popcount_pipe, each with valid/ready.
interface popcount_if #(
    parameter int WIDTH = 64,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_sat
    );
endinterface

// File: rtl/popcount_tree.sv
// Combinational slice of the count reduction: NLV levels, each level adds adjacent
// partial counts so entry i of level k holds the ones-count of bits [i*2^k, (i+1)*2^k).
module popcount_tree #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7,
    parameter int NLV   = 1
) (
    input  logic [WIDTH-1:0][CNT_W-1:0] lvl_i,
    output logic [WIDTH-1:0][CNT_W-1:0] lvl_o
);
    localparam int HALF = (WIDTH + 1) / 2;

    for (genvar l = 0; l <= NLV; l++) begin : g_lvl
        logic [WIDTH-1:0][CNT_W-1:0] v;
        if (l == 0) begin : g_in
            assign v = lvl_i;
        end else begin : g_add
            // Pad to an even number of terms so every pair is well formed.
            logic [2*HALF-1:0][CNT_W-1:0] pad;
            assign pad = (2 * HALF * CNT_W)'(g_lvl[l-1].v);
            always_comb begin
                v = '0;
                for (int i = 0; i < HALF; i++) begin
                    v[i] = pad[2*i] + pad[2*i+1];
                end
            end
        end
    end

    assign lvl_o = g_lvl[NLV].v;

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined ones-counter: reduction levels spread over LAT register stages, with a
// saturating burst accumulator folded into the final (output) stage.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LAT   = 2,
    parameter int ACC_W = 16
) (
    input logic        clk,
    input logic        nReset,
    popcount_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int NLVL  = $clog2(WIDTH);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("popcount_pipe: WIDTH must be 1..%0d", MAX_WIDTH);
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("popcount_pipe: LAT must be 1..4");
    end
    if (ACC_W < CNT_W) begin : g_bad_accw
        $error("popcount_pipe: ACC_W must be >= %0d", CNT_W);
    end

    logic                        stall;
    logic                        out_valid_q, out_valid_d;
    logic [ACC_W-1:0]            out_count_q, out_count_d;
    logic                        out_sat_q, out_sat_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic                        sticky_q, sticky_d;
    logic [WIDTH-1:0][CNT_W-1:0] lvl0;
    logic [WIDTH-1:0][CNT_W-1:0] lvl_out [LAT];
    beat_ctl_t                   ctl_pipe [LAT];

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        lvl0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lvl0[i] = CNT_W'(bus.in_data[i]);
        end
    end

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam lvl_span_t SPAN = stage_span(NLVL, LAT, s);
        logic [WIDTH-1:0][CNT_W-1:0] stg_in;

        if (s == 0) begin : g_head
            assign stg_in = lvl0;
            assign ctl_pipe[0] = '{vld: bus.in_valid && !stall,
                                   acc: bus.in_acc, last: bus.in_last};
        end else begin : g_reg
            logic [WIDTH-1:0][CNT_W-1:0] stg_q, stg_d;
            beat_ctl_t                   ctl_q, ctl_d;

            always_comb begin
                stg_d = stg_q;
                ctl_d = ctl_q;
                if (!stall) begin
                    stg_d = lvl_out[s-1];
                    ctl_d = ctl_pipe[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!nReset) begin
                    stg_q <= '0;
                    ctl_q <= '0;
                end else begin
                    stg_q <= stg_d;
                    ctl_q <= ctl_d;
                end
            end

            assign stg_in      = stg_q;
            assign ctl_pipe[s] = ctl_q;
        end

        popcount_tree #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W),
            .NLV   (SPAN.hi - SPAN.lo)
        ) u_tree (
            .lvl_i (stg_in),
            .lvl_o (lvl_out[s])
        );
    end

    // After the last level only entry 0 carries the total; the rest are zero.
    if (WIDTH > 1) begin : g_tail
        logic tree_unused;
        assign tree_unused = ^lvl_out[LAT-1][WIDTH-1:1];
    end

    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   sum;
    logic             clamp;
    logic [ACC_W-1:0] sat_sum;
    beat_ctl_t        fin;

    assign fin     = ctl_pipe[LAT-1];
    assign cnt     = lvl_out[LAT-1][0];
    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(cnt);
    assign clamp   = sum[ACC_W];
    assign sat_sum = clamp ? '1 : sum[ACC_W-1:0];

    always_comb begin
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            if (fin.vld && !fin.acc) begin
                out_valid_d = 1'b1;
                out_count_d = ACC_W'(cnt);
                out_sat_d   = 1'b0;
            end else if (fin.vld && !fin.last) begin
                // Mid-burst beat: fold into the running total, emit nothing.
                acc_d    = sat_sum;
                sticky_d = sticky_q | clamp;
            end else if (fin.vld) begin
                out_valid_d = 1'b1;
                out_count_d = sat_sum;
                out_sat_d   = sticky_q | clamp;
                acc_d       = '0;
                sticky_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

endmodule
